intrusion_alarm_fsm: RTL and testbench

INTRUSION_ALARM_FSM -- requirements
Module: intrusion_alarm_fsm

---
 rtl/intrusion_alarm_fsm.sv | 176 +++++++++++++++++
 tb/tb_intrusion_alarm_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/intrusion_alarm_fsm.sv
// Intrusion alarm controller: keypad code checker feeding a five-state arm/entry/alarm FSM.
// Code result is registered one cycle after the 4th digit; the FSM reacts on the cycle after that.
module intrusion_alarm_fsm #(
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int          EXIT_DELAY  = 10,
  parameter int          ENTRY_DELAY = 15,
  parameter int          ALARM_TIME  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       arm,
  input  logic       sensor,
  output logic [2:0] state,
  output logic [7:0] remaining,
  output logic       armed,
  output logic       delay_active,
  output logic       siren,
  output logic       code_ok,
  output logic       code_error
);

  localparam logic [2:0] S_DISARMED = 3'd0;
  localparam logic [2:0] S_EXIT     = 3'd1;
  localparam logic [2:0] S_ARMED    = 3'd2;
  localparam logic [2:0] S_ENTRY    = 3'd3;
  localparam logic [2:0] S_ALARM    = 3'd4;

  localparam logic [7:0] EXIT_TICKS  = 8'(EXIT_DELAY);
  localparam logic [7:0] ENTRY_TICKS = 8'(ENTRY_DELAY);
  localparam logic [7:0] ALARM_TICKS = 8'(ALARM_TIME);

  logic [15:0] code_buf;
  logic [1:0]  code_pos;
  logic [1:0]  fail_cnt;

  logic       good_digit;
  logic       bad_digit;
  logic       last_digit;
  logic       code_match;
  logic       code_mismatch;
  logic [2:0] state_nxt;
  logic [7:0] remaining_nxt;
  logic       alarm_expire;
  logic       clear_fail;

  // The oldest nibble shifts out as the 4th digit arrives, so only the low 16 bits are compared.
  always_comb begin
    good_digit    = digit_valid && (digit <= 4'd9);
    bad_digit     = digit_valid && (digit > 4'd9);
    last_digit    = good_digit && (code_pos == 2'd3);
    code_match    = last_digit && (({code_buf, digit} & 20'h0ffff) == {4'h0, CODE});
    code_mismatch = last_digit && !code_match;
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    alarm_expire  = 1'b0;
    case (state)
      S_DISARMED: begin
        if (arm) begin
          state_nxt     = S_EXIT;
          remaining_nxt = EXIT_TICKS;
        end
      end
      S_EXIT: begin
        if (code_ok) begin
          state_nxt     = S_DISARMED;
          remaining_nxt = 8'd0;
        end else if (tick) begin
          if (remaining == 8'd1) begin
            state_nxt     = S_ARMED;
            remaining_nxt = 8'd0;
          end else begin
            remaining_nxt = remaining - 8'd1;
          end
        end
      end
      S_ARMED: begin
        if (code_ok) begin
          state_nxt     = S_DISARMED;
          remaining_nxt = 8'd0;
        end else if (fail_cnt == 2'd3) begin
          state_nxt     = S_ALARM;
          remaining_nxt = ALARM_TICKS;
        end else if (sensor) begin
          state_nxt     = S_ENTRY;
          remaining_nxt = ENTRY_TICKS;
        end
      end
      S_ENTRY: begin
        if (code_ok) begin
          state_nxt     = S_DISARMED;
          remaining_nxt = 8'd0;
        end else if (fail_cnt == 2'd3) begin
          state_nxt     = S_ALARM;
          remaining_nxt = ALARM_TICKS;
        end else if (tick) begin
          if (remaining == 8'd1) begin
            state_nxt     = S_ALARM;
            remaining_nxt = ALARM_TICKS;
          end else begin
            remaining_nxt = remaining - 8'd1;
          end
        end
      end
      S_ALARM: begin
        if (code_ok) begin
          state_nxt     = S_DISARMED;
          remaining_nxt = 8'd0;
        end else if (tick) begin
          if (remaining == 8'd1) begin
            state_nxt     = S_ARMED;
            remaining_nxt = 8'd0;
            alarm_expire  = 1'b1;
          end else begin
            remaining_nxt = remaining - 8'd1;
          end
        end
      end
      default: begin
        state_nxt     = S_DISARMED;
        remaining_nxt = 8'd0;
      end
    endcase
    clear_fail = alarm_expire || ((state_nxt == S_DISARMED) && (state != S_DISARMED));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_buf   <= 16'h0000;
      code_pos   <= 2'd0;
      code_ok    <= 1'b0;
      code_error <= 1'b0;
    end else begin
      code_ok    <= code_match;
      code_error <= code_mismatch || bad_digit;
      if (bad_digit || last_digit) begin
        code_buf <= 16'h0000;
        code_pos <= 2'd0;
      end else if (good_digit) begin
        code_buf <= {code_buf[11:0], digit};
        code_pos <= code_pos + 2'd1;
      end
    end
  end

  // Clearing wins over a mismatch landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_cnt <= 2'd0;
    end else if (clear_fail || code_match) begin
      fail_cnt <= 2'd0;
    end else if (code_mismatch && (fail_cnt != 2'd3)) begin
      fail_cnt <= fail_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_DISARMED;
      remaining <= 8'd0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  assign armed        = (state == S_ARMED) || (state == S_ENTRY);
  assign delay_active = (state == S_EXIT)  || (state == S_ENTRY);
  assign siren        = (state == S_ALARM);

endmodule

// File: tb/tb_intrusion_alarm_fsm.sv
// Directed bench for intrusion_alarm_fsm with default parameters; expected values hand-computed.
module tb_intrusion_alarm_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0;
  logic       arm = 1'b0;
  logic       sensor = 1'b0;
  logic [2:0] state;
  logic [7:0] remaining;
  logic       armed;
  logic       delay_active;
  logic       siren;
  logic       code_ok;
  logic       code_error;

  int n_checks = 0;
  int n_fails  = 0;

  intrusion_alarm_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .arm          (arm),
    .sensor       (sensor),
    .state        (state),
    .remaining    (remaining),
    .armed        (armed),
    .delay_active (delay_active),
    .siren        (siren),
    .code_ok      (code_ok),
    .code_error   (code_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs and checks happen 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
    end
  endtask

  task automatic key(input logic [3:0] d);
    digit       = d;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_sense();
    sensor = 1'b1;
    step();
    sensor = 1'b0;
  endtask

  initial begin
    #2;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_remaining", 32'(remaining), 32'd0);
    check_eq("rst_siren", 32'(siren), 32'd0);
    check_eq("rst_code_ok", 32'(code_ok), 32'd0);
    check_eq("rst_code_error", 32'(code_error), 32'd0);
    #11 reset = 1'b1;
    step();

    // Arm without intrusion
    ticks(1);
    check_eq("disarmed_tick_ignored", 32'(state), 32'd0);
    do_arm();
    check_eq("exit_state", 32'(state), 32'd1);
    check_eq("exit_remaining", 32'(remaining), 32'd10);
    check_eq("exit_delay_active", 32'(delay_active), 32'd1);
    do_sense();
    check_eq("exit_sensor_ignored", 32'(state), 32'd1);
    ticks(9);
    check_eq("exit_rem_1", 32'(remaining), 32'd1);
    ticks(1);
    check_eq("armed_state", 32'(state), 32'd2);
    check_eq("armed_remaining", 32'(remaining), 32'd0);
    check_eq("armed_flag", 32'(armed), 32'd1);
    check_eq("armed_delay_off", 32'(delay_active), 32'd0);
    do_arm();
    ticks(1);
    check_eq("armed_arm_tick_ignored", 32'(state), 32'd2);

    // Intrusion through to alarm and back to armed
    do_sense();
    check_eq("entry_state", 32'(state), 32'd3);
    check_eq("entry_remaining", 32'(remaining), 32'd15);
    ticks(14);
    check_eq("entry_rem_1", 32'(remaining), 32'd1);
    check_eq("entry_no_siren", 32'(siren), 32'd0);
    ticks(1);
    check_eq("alarm_state", 32'(state), 32'd4);
    check_eq("alarm_siren", 32'(siren), 32'd1);
    check_eq("alarm_remaining", 32'(remaining), 32'd60);
    check_eq("alarm_not_armed", 32'(armed), 32'd0);
    ticks(59);
    check_eq("alarm_rem_1", 32'(remaining), 32'd1);
    ticks(1);
    check_eq("alarm_expire_state", 32'(state), 32'd2);
    check_eq("alarm_expire_siren", 32'(siren), 32'd0);

    // Disarm during entry
    do_sense();
    ticks(1);
    check_eq("entry_rem_14", 32'(remaining), 32'd14);
    key(4'd1); key(4'd2); key(4'd3);
    check_eq("partial_no_ok", 32'(code_ok), 32'd0);
    key(4'd4);
    check_eq("disarm_code_ok", 32'(code_ok), 32'd1);
    check_eq("disarm_no_error", 32'(code_error), 32'd0);
    check_eq("disarm_state_lag", 32'(state), 32'd3);
    step();
    check_eq("disarm_state", 32'(state), 32'd0);
    check_eq("disarm_remaining", 32'(remaining), 32'd0);
    check_eq("disarm_ok_one_cycle", 32'(code_ok), 32'd0);

    // Lockout after three wrong codes; an invalid digit does not count
    do_arm();
    ticks(10);
    check_eq("lock_armed", 32'(state), 32'd2);
    key(4'd12);
    check_eq("invalid_error", 32'(code_error), 32'd1);
    step();
    check_eq("invalid_error_cleared", 32'(code_error), 32'd0);
    for (int g = 0; g < 3; g++) begin
      key(4'd9); key(4'd9); key(4'd9); key(4'd9);
      check_eq("wrong_code_error", 32'(code_error), 32'd1);
      check_eq("wrong_code_no_ok", 32'(code_ok), 32'd0);
      step();
      check_eq("lock_state", 32'(state), (g == 2) ? 32'd4 : 32'd2);
    end
    check_eq("lock_siren", 32'(siren), 32'd1);
    check_eq("lock_remaining", 32'(remaining), 32'd60);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    step();
    check_eq("alarm_disarm", 32'(state), 32'd0);

    // code_ok collides with the final entry tick
    do_arm();
    ticks(10);
    do_sense();
    ticks(14);
    check_eq("coll_rem_1", 32'(remaining), 32'd1);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    check_eq("coll_code_ok", 32'(code_ok), 32'd1);
    ticks(1);
    check_eq("coll_state", 32'(state), 32'd0);
    check_eq("coll_siren", 32'(siren), 32'd0);
    check_eq("coll_remaining", 32'(remaining), 32'd0);

    // Asynchronous reset in ALARM with a partial code
    do_arm();
    ticks(10);
    do_sense();
    ticks(15);
    check_eq("ar_alarm", 32'(state), 32'd4);
    key(4'd1); key(4'd2);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_state", 32'(state), 32'd0);
    check_eq("ar_siren", 32'(siren), 32'd0);
    check_eq("ar_remaining", 32'(remaining), 32'd0);
    step();
    reset = 1'b1;
    step();
    key(4'd3); key(4'd4);
    check_eq("ar_no_ok", 32'(code_ok), 32'd0);
    check_eq("ar_no_error", 32'(code_error), 32'd0);
    key(4'd1); key(4'd2);
    check_eq("ar_fresh_mismatch", 32'(code_error), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
